// File: rtl/decode_stage_if.sv
// decode_stage_if
//   Bundles the fetch-side handshake, register-file read/write taps, flush and
//   the execute-side pipeline register outputs of the decode stage.
//   slave  : seen by decode_stage (fetch/regfile/wb/flush/out_ready in; rest out)
//   master : seen by the surrounding pipeline or a testbench
interface decode_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     in_instr;
  logic [DATA_WIDTH-1:0]     in_pc;
  logic [REG_ADDR_WIDTH-1:0] rs1;
  logic [REG_ADDR_WIDTH-1:0] rs2;
  logic [DATA_WIDTH-1:0]     rs1_value;
  logic [DATA_WIDTH-1:0]     rs2_value;
  logic                      wb_en;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]     wb_value;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH-1:0]     out_pc;
  logic [DATA_WIDTH-1:0]     out_rs1_value;
  logic [DATA_WIDTH-1:0]     out_rs2_value;
  logic [DATA_WIDTH-1:0]     out_imm;
  logic [REG_ADDR_WIDTH-1:0] out_rs1;
  logic [REG_ADDR_WIDTH-1:0] out_rs2;
  logic [REG_ADDR_WIDTH-1:0] out_rd;
  logic [6:0]                out_opcode;
  logic [2:0]                out_funct3;
  logic                      out_funct7_5;
  logic                      out_reg_write;
  logic                      out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, rs1_value, rs2_value,
           wb_en, wb_rd, wb_value, flush, out_ready,
    output in_ready, rs1, rs2, out_valid, out_pc, out_rs1_value, out_rs2_value,
           out_imm, out_rs1, out_rs2, out_rd, out_opcode, out_funct3,
           out_funct7_5, out_reg_write, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, rs1_value, rs2_value,
           wb_en, wb_rd, wb_value, flush, out_ready,
    input  in_ready, rs1, rs2, out_valid, out_pc, out_rs1_value, out_rs2_value,
           out_imm, out_rs1, out_rs2, out_rd, out_opcode, out_funct3,
           out_funct7_5, out_reg_write, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage
//   RV32I decode pipeline stage. Drives register-file read addresses straight
//   from the incoming instruction, selects operands (with same-edge writeback
//   bypass), decodes the immediate and control bits, and holds the result in
//   a one-entry output register for execute.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every output register
//   bus   : decode_stage_if.slave (fetch handshake, regfile taps, flush,
//           execute handshake and decoded outputs)
//
//   state (implicit in out_valid) | meaning
//   EMPTY (0)                     | no instruction held, ready for capture
//   FULL  (1)                     | instruction held for execute
module decode_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  decode_stage_if.slave  bus
);
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [DATA_WIDTH-1:0]     instr;
  logic [6:0]                opcode;
  logic [REG_ADDR_WIDTH-1:0] rs1_a, rs2_a, rd_a;
  logic [DATA_WIDTH-1:0]     op1, op2, imm;
  logic                      legal, no_rd;
  logic                      capture;

  logic                      valid_q;
  logic [DATA_WIDTH-1:0]     pc_q, rs1_value_q, rs2_value_q, imm_q;
  logic [REG_ADDR_WIDTH-1:0] rs1_q, rs2_q, rd_q;
  logic [6:0]                opcode_q;
  logic [2:0]                funct3_q;
  logic                      funct7_5_q, reg_write_q, illegal_q;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign rs1_a  = instr[19:15];
  assign rs2_a  = instr[24:20];
  assign rd_a   = instr[11:7];

  assign bus.rs1 = rs1_a;
  assign bus.rs2 = rs2_a;

  assign bus.in_ready = !bus.flush && (!valid_q || bus.out_ready);
  assign capture      = bus.in_valid && bus.in_ready;

  // The regfile write landing on the capture edge is not yet visible on
  // rsN_value, so forward it here. x0 always reads as zero.
  always_comb begin
    op1 = bus.rs1_value;
    op2 = bus.rs2_value;
    if (bus.wb_en && (bus.wb_rd == rs1_a)) op1 = bus.wb_value;
    if (bus.wb_en && (bus.wb_rd == rs2_a)) op2 = bus.wb_value;
    if (rs1_a == '0) op1 = '0;
    if (rs2_a == '0) op2 = '0;
  end

  always_comb begin
    imm   = '0;
    legal = 1'b1;
    no_rd = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE: begin
        imm   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        no_rd = 1'b1;
      end
      OPC_BRANCH: begin
        imm   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        no_rd = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: imm = {instr[31:12], 12'b0};
      OPC_JAL:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      OPC_OP:    imm = '0;
      default:   legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_value_q <= '0;
      rs2_value_q <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      opcode_q    <= '0;
      funct3_q    <= '0;
      funct7_5_q  <= 1'b0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q     <= 1'b1;
      pc_q        <= bus.in_pc;
      rs1_value_q <= op1;
      rs2_value_q <= op2;
      imm_q       <= imm;
      rs1_q       <= rs1_a;
      rs2_q       <= rs2_a;
      rd_q        <= rd_a;
      opcode_q    <= opcode;
      funct3_q    <= instr[14:12];
      funct7_5_q  <= instr[30];
      reg_write_q <= legal && !no_rd && (rd_a != '0);
      illegal_q   <= !legal;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end else if (valid_q) begin
      // Stalled: keep held operands coherent with writes retiring behind us.
      if (bus.wb_en && (bus.wb_rd != '0) && (bus.wb_rd == rs1_q)) rs1_value_q <= bus.wb_value;
      if (bus.wb_en && (bus.wb_rd != '0) && (bus.wb_rd == rs2_q)) rs2_value_q <= bus.wb_value;
    end
  end

  assign bus.out_valid     = valid_q;
  assign bus.out_pc        = pc_q;
  assign bus.out_rs1_value = rs1_value_q;
  assign bus.out_rs2_value = rs2_value_q;
  assign bus.out_imm       = imm_q;
  assign bus.out_rs1       = rs1_q;
  assign bus.out_rs2       = rs2_q;
  assign bus.out_rd        = rd_q;
  assign bus.out_opcode    = opcode_q;
  assign bus.out_funct3    = funct3_q;
  assign bus.out_funct7_5  = funct7_5_q;
  assign bus.out_reg_write = reg_write_q;
  assign bus.out_illegal   = illegal_q;
endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  decode_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] rf [32];
  assign bus.rs1_value = rf[bus.rs1];
  assign bus.rs2_value = rf[bus.rs2];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, v1, v2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f75, rw, ill;
  } rec_t;

  rec_t m = '0;

  // Spec-level decode: immediates rebuilt with arithmetic on the signed word.
  function automatic rec_t decode(input logic [31:0] i, input logic [31:0] pc);
    rec_t r;
    logic legal;
    logic [31:0] sgn;
    sgn = ($signed(i) >>> 31);
    r = '0;
    r.valid = 1'b1;
    r.pc  = pc;
    r.rs1 = i[19:15];
    r.rs2 = i[24:20];
    r.rd  = i[11:7];
    r.op  = i[6:0];
    r.f3  = i[14:12];
    r.f75 = i[30];
    legal = 1'b1;
    case (i[6:0])
      7'h03, 7'h13, 7'h67: r.imm = $signed(i) >>> 20;
      7'h23: r.imm = (($signed(i) >>> 25) * 32) + i[11:7];
      7'h63: r.imm = sgn * 4096 + i[7] * 2048 + i[30:25] * 32 + i[11:8] * 2;
      7'h37, 7'h17: r.imm = i & 32'hFFFFF000;
      7'h6F: r.imm = sgn * 1048576 + i[19:12] * 4096 + i[20] * 2048 + i[30:21] * 2;
      7'h33: r.imm = 0;
      default: begin legal = 1'b0; r.imm = 0; end
    endcase
    r.ill = !legal;
    r.rw  = legal && (i[6:0] != 7'h63) && (i[6:0] != 7'h23) && (r.rd != 0);
    if (r.rs1 == 0) r.v1 = 0;
    else if (bus.wb_en && bus.wb_rd == r.rs1) r.v1 = bus.wb_value;
    else r.v1 = rf[r.rs1];
    if (r.rs2 == 0) r.v2 = 0;
    else if (bus.wb_en && bus.wb_rd == r.rs2) r.v2 = bus.wb_value;
    else r.v2 = rf[r.rs2];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin : mdl
    rec_t n;
    logic rdy;
    if (!rst_n) begin
      m <= '0;
    end else begin
      n   = m;
      rdy = !bus.flush && (!m.valid || bus.out_ready);
      if (bus.flush) n.valid = 1'b0;
      else if (bus.in_valid && rdy) n = decode(bus.in_instr, bus.in_pc);
      else if (bus.out_ready) n.valid = 1'b0;
      else if (m.valid && bus.wb_en && bus.wb_rd != 0) begin
        if (bus.wb_rd == m.rs1) n.v1 = bus.wb_value;
        if (bus.wb_rd == m.rs2) n.v2 = bus.wb_value;
      end
      m <= n;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, !bus.flush && (!m.valid || bus.out_ready)});
    chk("rs1", {27'b0, bus.rs1}, {27'b0, bus.in_instr[19:15]});
    chk("rs2", {27'b0, bus.rs2}, {27'b0, bus.in_instr[24:20]});
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m.valid});
    if (m.valid || !rst_n) begin
      chk("out_pc", bus.out_pc, m.pc);
      chk("out_rs1_value", bus.out_rs1_value, m.v1);
      chk("out_rs2_value", bus.out_rs2_value, m.v2);
      chk("out_imm", bus.out_imm, m.imm);
      chk("out_rs1", {27'b0, bus.out_rs1}, {27'b0, m.rs1});
      chk("out_rs2", {27'b0, bus.out_rs2}, {27'b0, m.rs2});
      chk("out_rd", {27'b0, bus.out_rd}, {27'b0, m.rd});
      chk("out_opcode", {25'b0, bus.out_opcode}, {25'b0, m.op});
      chk("out_funct3", {29'b0, bus.out_funct3}, {29'b0, m.f3});
      chk("out_funct7_5", {31'b0, bus.out_funct7_5}, {31'b0, m.f75});
      chk("out_reg_write", {31'b0, bus.out_reg_write}, {31'b0, m.rw});
      chk("out_illegal", {31'b0, bus.out_illegal}, {31'b0, m.ill});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADDI = 32'hFFF08293;

  logic [31:0] dec_instr [6];
  logic [31:0] dec_imm   [6];

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = 32'h1111_1111 * r;
    rf[1] = 32'hFF00AA55;
    rf[2] = 32'h0000_0222;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'h0000_0013;
    bus.in_pc     = 32'h0000_1000;
    bus.wb_en     = 1'b0;
    bus.wb_rd     = 5'd0;
    bus.wb_value  = 32'h0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    step(); step();
    chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // Fill and stall, then reset asynchronously while FULL.
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = ADDI;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    step(); step();
    chk("stall_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("arst_imm", bus.out_imm, 32'd0);
    chk("arst_rd", {27'b0, bus.out_rd}, 32'd0);
    chk("arst_rs1_value", bus.out_rs1_value, 32'd0);
    chk("arst_pc", bus.out_pc, 32'd0);
    chk("arst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    chk("addi_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("addi_rd", {27'b0, bus.out_rd}, 32'd5);
    chk("addi_rs1", {27'b0, bus.out_rs1}, 32'd1);
    chk("addi_imm", bus.out_imm, 32'hFFFFFFFF);
    chk("addi_rs1_value", bus.out_rs1_value, 32'hFF00AA55);
    chk("addi_reg_write", {31'b0, bus.out_reg_write}, 32'd1);
    chk("addi_illegal", {31'b0, bus.out_illegal}, 32'd0);

    // Bypass at the capture edge, then x0 write is not forwarded.
    bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_value = 32'h12345678;
    step();
    chk("bypass_rs1_value", bus.out_rs1_value, 32'h12345678);
    bus.wb_rd = 5'd0;
    step();
    chk("bypass_x0_rs1_value", bus.out_rs1_value, 32'hFF00AA55);

    // Backpressure with a refresh write during the stall.
    bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_value = 32'hDEADBEEF;
    bus.out_ready = 1'b0;
    step();
    bus.wb_en = 1'b0;
    chk("refresh_rs1_value", bus.out_rs1_value, 32'hDEADBEEF);
    step(); step();
    chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("bp_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("bp_rs1_value", bus.out_rs1_value, 32'hDEADBEEF);
    chk("bp_imm", bus.out_imm, 32'hFFFFFFFF);

    // Back-to-back transfers of decode corner cases.
    bus.in_instr = 32'h0020A423; bus.in_pc = 32'h0000_2000; bus.out_ready = 1'b1;
    step();
    chk("sw_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("sw_imm", bus.out_imm, 32'd8);
    chk("sw_rs2", {27'b0, bus.out_rs2}, 32'd2);
    chk("sw_reg_write", {31'b0, bus.out_reg_write}, 32'd0);
    bus.in_instr = 32'h0000007F; bus.in_pc = 32'h0000_2004;
    step();
    chk("ill_illegal", {31'b0, bus.out_illegal}, 32'd1);
    chk("ill_reg_write", {31'b0, bus.out_reg_write}, 32'd0);
    chk("ill_imm", bus.out_imm, 32'd0);
    bus.in_instr = 32'hFFF08013; bus.in_pc = 32'h0000_2008;
    step();
    chk("rd0_reg_write", {31'b0, bus.out_reg_write}, 32'd0);
    chk("rd0_valid", {31'b0, bus.out_valid}, 32'd1);

    // Flush while FULL and stalled with a valid incoming instruction.
    bus.out_ready = 1'b0; bus.flush = 1'b1;
    bus.in_instr = 32'h00100093; bus.in_pc = 32'h0000_3000;
    #1;
    chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd0);
    step();
    chk("flush_valid", {31'b0, bus.out_valid}, 32'd0);
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    chk("flush_no_capture", {31'b0, bus.out_valid}, 32'd0);

    // Immediate formats, streamed with assorted writeback traffic.
    dec_instr[0] = 32'h123450B7; dec_imm[0] = 32'h12345000;
    dec_instr[1] = 32'hFE208EE3; dec_imm[1] = 32'hFFFFFFFC;
    dec_instr[2] = 32'h008000EF; dec_imm[2] = 32'h00000008;
    dec_instr[3] = 32'h002081B3; dec_imm[3] = 32'h00000000;
    dec_instr[4] = 32'h00001117; dec_imm[4] = 32'h00001000;
    dec_instr[5] = 32'h0040A183; dec_imm[5] = 32'h00000004;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.in_instr = dec_instr[k];
      bus.in_pc    = 32'h0000_4000 + 32'(4 * k);
      bus.wb_en    = k[0];
      bus.wb_rd    = 5'(k % 3);
      bus.wb_value = 32'hA5A5_0000 + 32'(k);
      step();
      chk("fmt_imm", bus.out_imm, dec_imm[k]);
    end
    bus.in_valid = 1'b0; bus.wb_en = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode pipeline stage that sits directly upstream of the `Registers` file. It takes one RV32I instruction per handshake from fetch and drives the register file's `rs1`/`rs2` read addresses. It captures the read operands, the decoded fields and the immediate into an output pipeline register for execute. It bypasses same-cycle writeback data and refreshes held operands while stalled.

## Interface
- `DATA_WIDTH`, 32, operand/PC/instruction width
- `REG_ADDR_WIDTH`, 5, register index width

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid` / `in_ready`  in / out  1  fetch-side handshake
- `in_instr`, `in_pc`  in  32  instruction word and its PC
- `rs1`, `rs2`  out  5  read addresses to register file, combinational from `in_instr[19:15]` / `in_instr[24:20]`
- `rs1_value`, `rs2_value`  in  32  register file async read data
- `wb_en`, `wb_rd`, `wb_value`  in  1/5/32  same signals that drive the register file write port (`reg_write_en`, `rd`, `rd_value`)
- `flush`  in  1  squash the held and incoming instruction
- `out_valid` / `out_ready`  out / in  1  execute-side handshake
- `out_pc`, `out_rs1_value`, `out_rs2_value`, `out_imm`  out  32
- `out_rs1`, `out_rs2`, `out_rd`  out  5
- `out_opcode` (7), `out_funct3` (3), `out_funct7_5` (1, instr bit 30)  out
- `out_reg_write`, `out_illegal`  out  1

## Operation
- Handshake: `in_ready = !flush && (!out_valid || out_ready)`. Capture occurs on a rising edge with `in_valid && in_ready`.
- Operand select, per source: if `wb_en && wb_rd != 0 && wb_rd == rsN`, use `wb_value`. Otherwise use `rsN_value`. When `rsN == 0`, the operand is 0 regardless.
- Immediate, sign-extended from bit 31:
  - I-type: LOAD 0000011, OP-IMM 0010011, JALR 1100111
  - S-type: STORE 0100011
  - B-type: BRANCH 1100011, bit 0 = 0
  - U-type: LUI 0110111, AUIPC 0010111, low 12 bits = 0
  - J-type: JAL 1101111, bit 0 = 0
  - R-type: OP 0110011, imm = 0
- Illegal opcode (any opcode not listed above): `out_illegal=1`, `out_reg_write=0`, imm = 0.
- `out_reg_write = 1` only for a legal opcode that is not BRANCH or STORE and has `rd != 0`.
- Hold refresh: while `out_valid && !out_ready`, a write with `wb_en && wb_rd != 0 && wb_rd == out_rsN` loads `wb_value` into `out_rsN_value` at that edge. All other outputs stay stable.
- Flush: at the next edge `out_valid <= 0`. The incoming instruction is not captured. Flush has priority over capture and over hold refresh.
- `out_valid` register update, in priority order:
  - 0 on flush
  - 1 on capture
  - 0 when `out_ready` is high and there is no capture
  - otherwise hold
- States are implicit in `out_valid`: EMPTY (0) and FULL (1).
  - EMPTY -> FULL on capture.
  - FULL -> FULL on simultaneous consume and capture (back-to-back, no bubble).
  - FULL -> EMPTY on consume without capture, or on flush.

## Timing
- Latency: 1 cycle from capture edge to `out_valid` high. Sustained throughput is 1 instruction per cycle when `out_ready` is held high.
- `rs1`/`rs2` are purely combinational from `in_instr`. The register file read is asynchronous, so operands are sampled at the capture edge.
- Bypass covers a register file write at the same edge as capture, because that write is not yet visible on `rsN_value`.
- Reset (`rst_n` low, asynchronous, including mid-stall):
  - `out_valid=0` and every `out_*` register = 0.
  - `in_ready` follows its formula, so it is 1 when `flush=0`.
  - On release, the first capture can occur at the first rising edge.
- Simultaneous `flush` and `out_ready`: the held instruction is dropped with no transfer. Execute must ignore it.

## Test plan
- Reset: drive `rst_n=0` while FULL and stalled -> `out_valid=0`, all outputs 0, `in_ready=1`. Release, then issue ADDI -> accepted on the first edge.
- ADDI x5,x1,-1 (`0xFFF08293`) with x1 = `0xFF00AA55` -> after 1 cycle:
  - `out_valid=1`, `out_rd=5`, `out_rs1=1`
  - `out_imm=0xFFFFFFFF`, `out_rs1_value=0xFF00AA55`
  - `out_reg_write=1`, `out_illegal=0`
- Bypass: same ADDI with `wb_en=1`, `wb_rd=1`, `wb_value=0x12345678` at the capture edge -> `out_rs1_value=0x12345678`. Repeat with `wb_rd=0` -> the register file value is used.
- Backpressure: FULL with ADDI, `out_ready=0` for 3 cycles -> `in_ready=0` and outputs stable. A write of `0xDEADBEEF` to x1 during the stall -> `out_rs1_value=0xDEADBEEF` from the next cycle. Then set `out_ready=1` with the next instruction valid -> back-to-back transfer, `out_valid` stays 1.
- Flush: `flush=1` with `in_valid=1` while FULL -> next cycle `out_valid=0`, incoming instruction not captured, `in_ready=0` during the flush cycle.
- Decode:
  - SW x2,8(x1) (`0x0020A423`) -> `out_imm=8`, `out_reg_write=0`, `out_rs2=2`.
  - Opcode `0x0000007F` -> `out_illegal=1`, `out_reg_write=0`.
  - ADDI with rd=0 (`0xFFF08013`) -> `out_reg_write=0`.
